// File: rtl/softmax_seq_pipe.sv
// softmax_seq_pipe: sequential softmax over N signed fixed-point logits.
// Flow: LOAD (stream in, track max) -> EXP (base-2 Mitchell exponentials,
// accumulate denominator) -> DIV (shared restoring divider) -> OUT (stream out).
// Optional build macro SOFTMAX_ARGMAX_EN adds argmax_idx / argmax_valid ports.
// The element buffer is W_IN wide, so FRAC < W_IN is assumed (E_W <= W_IN).
module softmax_seq_pipe #(
    parameter int N     = 8,
    parameter int W_IN  = 16,
    parameter int FRAC  = 8,
    parameter int OUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_IN-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
`ifdef SOFTMAX_ARGMAX_EN
    output logic [$clog2(N)-1:0] argmax_idx,
    output logic                 argmax_valid,
`endif
    output logic                 busy
);

    localparam int E_W     = FRAC + 1;
    localparam int S_W     = E_W + $clog2(N);
    localparam int IDX_W   = $clog2(N);
    localparam int DC_W    = $clog2(OUT_W + 2);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_EXP  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(OUT_W + 1);

    logic [1:0]             state_r;
    logic [IDX_W-1:0]       cnt_r;
    logic signed [W_IN-1:0] max_r;
    logic [S_W-1:0]         sum_r;
    logic [W_IN-1:0]        buf_r [N];
    logic [S_W-1:0]         rem_r;
    logic [OUT_W:0]         quo_r;
    logic [DC_W-1:0]        div_cnt_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [OUT_W-1:0]       out_data_r;
    logic [IDX_W-1:0]       out_idx_r;
    logic                   out_last_r;
    logic                   busy_r;
`ifdef SOFTMAX_ARGMAX_EN
    logic [IDX_W-1:0]       max_idx_r;
    logic [IDX_W-1:0]       argmax_idx_r;
    logic                   argmax_valid_r;
`endif

    logic                   in_gt_max_s;
    logic signed [W_IN-1:0] x_s;
    logic signed [W_IN:0]   d_s;
    logic signed [W_IN:0]   k_s;
    logic signed [W_IN:0]   negk_s;
    logic [E_W-1:0]         mant_s;
    logic [E_W-1:0]         e_s;
    logic [E_W-1:0]         e_div_s;
    logic [S_W:0]           trial_s;
    logic [S_W:0]           sub_s;
    logic                   ge_s;
    logic [S_W-1:0]         rem_nxt_s;
    logic [OUT_W:0]         quo_nxt_s;
    logic [OUT_W-1:0]       sat_s;

    // Exponential term of the element addressed by cnt_r, and one divider step.
    always_comb begin
        in_gt_max_s = ($signed(in_data) > max_r);
        x_s     = $signed(buf_r[cnt_r]);
        d_s     = {x_s[W_IN-1], x_s} - {max_r[W_IN-1], max_r};
        k_s     = d_s >>> FRAC;
        negk_s  = -k_s;
        mant_s  = {1'b1, d_s[FRAC-1:0]};
        if (negk_s >= $signed((W_IN + 1)'(E_W))) begin
            e_s = '0;
        end else begin
            e_s = mant_s >> negk_s;
        end
        e_div_s = buf_r[cnt_r][E_W-1:0];
        trial_s = {rem_r, quo_r[OUT_W]};
        sub_s   = trial_s - {1'b0, sum_r};
        ge_s    = (trial_s >= {1'b0, sum_r});
        if (ge_s) begin
            rem_nxt_s = sub_s[S_W-1:0];
        end else begin
            rem_nxt_s = trial_s[S_W-1:0];
        end
        quo_nxt_s = {quo_r[OUT_W-1:0], ge_s};
        if (quo_nxt_s[OUT_W]) begin
            sat_s = {OUT_W{1'b1}};
        end else begin
            sat_s = quo_nxt_s[OUT_W-1:0];
        end
    end

    // Control FSM with buffer, running max, denominator and divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            cnt_r       <= '0;
            max_r       <= '0;
            sum_r       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            div_cnt_r   <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_r[i] <= '0;
            end
`ifdef SOFTMAX_ARGMAX_EN
            max_idx_r      <= '0;
            argmax_idx_r   <= '0;
            argmax_valid_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (in_valid && in_ready_r) begin
                        buf_r[cnt_r] <= in_data;
                        busy_r       <= 1'b1;
                        // Strict compare: ties keep the earlier index.
                        if ((cnt_r == '0) || in_gt_max_s) begin
                            max_r <= $signed(in_data);
`ifdef SOFTMAX_ARGMAX_EN
                            max_idx_r <= cnt_r;
`endif
                        end
                        if (cnt_r == IDX_LAST) begin
                            state_r    <= ST_EXP;
                            cnt_r      <= '0;
                            in_ready_r <= 1'b0;
`ifdef SOFTMAX_ARGMAX_EN
                            argmax_idx_r   <= in_gt_max_s ? cnt_r : max_idx_r;
                            argmax_valid_r <= 1'b1;
`endif
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                ST_EXP: begin
                    buf_r[cnt_r] <= W_IN'(e_s);
                    sum_r        <= sum_r + S_W'(e_s);
                    if (cnt_r == IDX_LAST) begin
                        state_r   <= ST_DIV;
                        cnt_r     <= '0;
                        div_cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_cnt_r == '0) begin
                        // Dividend is e<<OUT_W; its bits above the quotient
                        // field seed the remainder, e[0] is the first shifted bit.
                        rem_r     <= S_W'(e_div_s >> 1);
                        quo_r     <= {e_div_s[0], {OUT_W{1'b0}}};
                        div_cnt_r <= div_cnt_r + 1'b1;
                    end else begin
                        rem_r <= rem_nxt_s;
                        quo_r <= quo_nxt_s;
                        if (div_cnt_r == DC_LAST) begin
                            state_r     <= ST_OUT;
                            out_valid_r <= 1'b1;
                            out_data_r  <= sat_s;
                            out_idx_r   <= cnt_r;
                            out_last_r  <= (cnt_r == IDX_LAST);
                        end else begin
                            div_cnt_r <= div_cnt_r + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (cnt_r == IDX_LAST) begin
                            state_r    <= ST_LOAD;
                            cnt_r      <= '0;
                            sum_r      <= '0;
                            max_r      <= '0;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
`ifdef SOFTMAX_ARGMAX_EN
                            argmax_valid_r <= 1'b0;
`endif
                        end else begin
                            state_r   <= ST_DIV;
                            cnt_r     <= cnt_r + 1'b1;
                            div_cnt_r <= '0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
`ifdef SOFTMAX_ARGMAX_EN
    assign argmax_idx   = argmax_idx_r;
    assign argmax_valid = argmax_valid_r;
`endif

endmodule
